// File: rtl/score_bcd.sv
// score_bcd: iterative binary-to-BCD converter (double dabble, one bit per clock)
// with a start/done handshake and held decimal digits for the score renderer.
module score_bcd #(
    parameter int BIN_WIDTH = 14,
    parameter int DIGITS    = 4,
    parameter int MAX_VALUE = 9999
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [BIN_WIDTH-1:0]    value,
    output logic                    busy,
    output logic                    done,
    output logic [DIGITS*4-1:0]     digits,
    output logic                    overflow
);

    localparam int                   CNT_W      = $clog2(BIN_WIDTH + 1);
    localparam logic [CNT_W-1:0]     LAST_COUNT = CNT_W'(BIN_WIDTH - 1);
    localparam logic [BIN_WIDTH-1:0] MAX_BIN    = BIN_WIDTH'(MAX_VALUE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [BIN_WIDTH-1:0]    bin;
    logic [DIGITS*4-1:0]     scratch;
    logic [DIGITS*4-1:0]     scratch_adj;
    logic [CNT_W-1:0]        count;
    logic                    ovf_pending;

    // Both SHIFT and DONE count as busy so the renderer can tell a result is pending
    assign busy = (state != IDLE);

    // State register; reset aborts any conversion in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: accept in IDLE, shift BIN_WIDTH times, then one DONE cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (count == LAST_COUNT) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Add-3 correction: every nibble of 5 or more gets +3 before the shift, no carries
    always_comb begin
        scratch_adj = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    // Datapath: saturate and load on accept, shift while converting, publish on DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin         <= '0;
            scratch     <= '0;
            count       <= '0;
            ovf_pending <= 1'b0;
            digits      <= '0;
            overflow    <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bin         <= (value > MAX_BIN) ? MAX_BIN : value;
                        ovf_pending <= (value > MAX_BIN);
                        scratch     <= '0;
                        count       <= '0;
                    end
                end
                SHIFT: begin
                    scratch <= {scratch_adj[DIGITS*4-2:0], bin[BIN_WIDTH-1]};
                    bin     <= {bin[BIN_WIDTH-2:0], 1'b0};
                    count   <= count + CNT_W'(1);
                end
                DONE: begin
                    digits   <= scratch;
                    overflow <= ovf_pending;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_score_bcd.sv
// tb_score_bcd: self-checking bench for score_bcd against a decimal-arithmetic model.
module tb_score_bcd;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [13:0] value = '0;
    logic        busy;
    logic        done;
    logic [15:0] digits;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // Model state: cycles left until the done edge, the accepted value, published result
    int          m_left   = 0;
    int          m_val    = 0;
    logic        m_done   = 1'b0;
    logic [15:0] m_digits = '0;
    logic        m_ovf    = 1'b0;

    score_bcd dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .value    (value),
        .busy     (busy),
        .done     (done),
        .digits   (digits),
        .overflow (overflow)
    );

    // Free-running clock, 10 time units per cycle
    always #5 clk = ~clk;

    // Edge counter used to measure done-to-done periods
    always @(posedge clk) cycle <= cycle + 1;

    // Saturate to 9999 and split into decimal digits with plain division
    function automatic logic [15:0] to_bcd(input int v);
        int s;
        s = (v > 9999) ? 9999 : v;
        return {4'(s / 1000 % 10), 4'(s / 100 % 10), 4'(s / 10 % 10), 4'(s % 10)};
    endfunction

    function automatic logic [13:0] pick_value();
        case ($urandom_range(0, 5))
            0:       return 14'($urandom_range(0, 15));
            1:       return 14'($urandom_range(9990, 10010));
            2:       return 14'($urandom_range(16370, 16383));
            default: return 14'($urandom_range(0, 16383));
        endcase
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (time %0t)", name, actual, expected, $time);
        end
    endtask

    // Drive a one-cycle start pulse; inputs change 2 units after the rising edge
    task automatic apply_stimulus(input logic [13:0] v);
        @(posedge clk);
        #2;
        start = 1'b1;
        value = v;
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic count_dones(input int n_cycles, output int n);
        n = 0;
        for (int i = 0; i < n_cycles; i++) begin
            @(negedge clk);
            if (done === 1'b1) n++;
        end
    endtask

    task automatic run_conv(input logic [13:0] v, input logic [15:0] exp_bcd, input logic exp_ovf);
        bit found;
        apply_stimulus(v);
        wait_done(40, found);
        check_output("done_seen", 32'(found), 32'd1);
        check_output("conv_digits", 32'(digits), 32'(exp_bcd));
        check_output("conv_overflow", 32'(overflow), 32'(exp_ovf));
    endtask

    // Model: accept only when idle, report 15 edges later, reset clears everything
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left   <= 0;
            m_done   <= 1'b0;
            m_digits <= '0;
            m_ovf    <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_done   <= 1'b1;
                    m_digits <= to_bcd(m_val);
                    m_ovf    <= (m_val > 9999);
                end
            end else if (start) begin
                m_left <= 15;
                m_val  <= int'(value);
            end
        end
    end

    // Every falling edge: all DUT outputs must match the model
    always @(negedge clk) begin
        check_output("model_busy", 32'(busy), 32'(m_left > 0));
        check_output("model_done", 32'(done), 32'(m_done));
        check_output("model_digits", 32'(digits), 32'(m_digits));
        check_output("model_overflow", 32'(overflow), 32'(m_ovf));
    end

    initial begin
        bit found;
        int edges;
        int busy_cycles;
        int n;
        int t0;
        int t1;

        // Reset and idle: everything stays zero
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check_output("idle_digits", 32'(digits), 32'h0);
        check_output("idle_done", 32'(done), 32'd0);
        check_output("idle_busy", 32'(busy), 32'd0);

        // 1234: latency of 15 edges and 15 busy cycles
        @(posedge clk);
        #2;
        start = 1'b1;
        value = 14'd1234;
        @(posedge clk);
        #2;
        start = 1'b0;
        edges = 0;
        busy_cycles = 0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cycles++;
            if (done === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(posedge clk);
            edges++;
        end
        check_output("lat_done_seen", 32'(found), 32'd1);
        check_output("lat_edges", 32'(edges), 32'd15);
        check_output("lat_busy_cycles", 32'(busy_cycles), 32'd15);
        check_output("lit_1234", 32'(digits), 32'h1234);
        check_output("lit_1234_ovf", 32'(overflow), 32'd0);

        // Boundary values back to back
        run_conv(14'd0,     16'h0000, 1'b0);
        run_conv(14'd9,     16'h0009, 1'b0);
        run_conv(14'd10,    16'h0010, 1'b0);
        run_conv(14'd9999,  16'h9999, 1'b0);
        run_conv(14'd16383, 16'h9999, 1'b1);
        run_conv(14'd42,    16'h0042, 1'b0);

        // Start and value changes during a conversion are ignored
        apply_stimulus(14'd5678);
        repeat (3) @(posedge clk);
        #2;
        start = 1'b1;
        value = 14'd1111;
        @(posedge clk);
        #2;
        start = 1'b0;
        value = 14'($urandom_range(0, 16383));
        wait_done(40, found);
        check_output("ign_done_seen", 32'(found), 32'd1);
        check_output("ign_digits", 32'(digits), 32'h5678);
        count_dones(20, n);
        check_output("ign_no_second_done", 32'(n), 32'd0);

        // Start held high: one conversion every 16 cycles
        @(posedge clk);
        #2;
        start = 1'b1;
        value = 14'd777;
        wait_done(40, found);
        t0 = cycle;
        wait_done(40, found);
        t1 = cycle;
        check_output("held_period_a", 32'(t1 - t0), 32'd16);
        t0 = t1;
        wait_done(40, found);
        t1 = cycle;
        check_output("held_period_b", 32'(t1 - t0), 32'd16);
        check_output("held_digits", 32'(digits), 32'h0777);
        #2;
        start = 1'b0;
        wait_done(40, found);

        // Reset after the seventh shift of 4321 aborts it silently
        @(posedge clk);
        #2;
        start = 1'b1;
        value = 14'd4321;
        @(posedge clk);
        #2;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_output("rst_digits", 32'(digits), 32'h0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_done", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        count_dones(25, n);
        check_output("rst_no_done", 32'(n), 32'd0);
        run_conv(14'd4321, 16'h4321, 1'b0);

        // Random traffic, including occasional held start and rare resets
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk);
            #2;
            if ($urandom_range(0, 399) == 0) begin
                rst_n = 1'b0;
                start = 1'b0;
                @(posedge clk);
                #2 rst_n = 1'b1;
            end else begin
                start = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 1) == 0) value = pick_value();
            end
        end
        start = 1'b0;
        repeat (20) @(posedge clk);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
